regfile_multiport: RTL and testbench

Parametrised multi-read, single-write register file for the datapath, replacing the fixed 32×32 register array and its 32:1 read mux.
- Provides NUM_RD independently addressed read ports with registered outputs and a per-port valid.
- Hardwires one architectural zero register.
- Runs a post-reset initialisation sweep that zeroes every entry before it accepts traffic.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 61 ++++++
 rtl/regfile_multiport.sv | 100 ++++++++++
 tb/tb_regfile_multiport.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state type, default parameters and address-width helper for regfile_multiport
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ZERO_REG = 31;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port: entry select, zero-register mask, optional write bypass
// Bypass compare is present only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W  = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  entries_i [DEPTH],
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_valid_o
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_comb begin
    sel_data = entries_i[rd_addr_i];
    if (32'(rd_addr_i) == ZERO_REG) begin
      sel_data = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // wr_fire_i already excludes the zero register, so the mask above stays authoritative
    if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
      sel_data = wr_data_i;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_fire_i, wr_addr_i, wr_data_i};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ready_i && rd_en_i;
      if (ready_i && rd_en_i) begin
        rd_data_q <= sel_data;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NUM_RD-read / 1-write register file with zero register and post-reset clear sweep
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W  = addr_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     init_busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              ready;
  logic              wr_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready     = (state_q == READY);
  assign init_busy = (state_q == INIT);
  assign wr_fire   = ready && wr_en && (32'(wr_addr) != ZERO_REG);

  // The sweep borrows the single write port, so user writes need no arbitration
  assign mem_we    = init_busy || wr_fire;
  assign mem_waddr = init_busy ? cnt_q : wr_addr;
  assign mem_wdata = init_busy ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk        (clk),
      .reset      (reset),
      .ready_i    (ready),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
      .entries_i  (mem_q),
      .wr_fire_i  (wr_fire),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data[p*WIDTH +: WIDTH]),
      .rd_valid_o (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport with a behavioural array model
module tb_regfile_multiport;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NUM_RD = 2;
  localparam int ZREG = 31;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     init_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];

  regfile_multiport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(ZREG)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int addr, input bit we, input int wa,
                                                  input logic [WIDTH-1:0] wd);
    if (addr == ZREG) return '0;
    if (BYPASS && we && wa == addr) return wd;
    return ref_mem[addr];
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
  endtask

  // Counts edges from reset release until init_busy falls, with a hard bound
  task automatic release_and_count(output int n, output int leaked);
    reset = 1'b0;
    n = 0;
    leaked = 0;
    do begin
      tick();
      n++;
      if (rd_valid !== '0) leaked++;
    end while (init_busy === 1'b1 && n < 100);
    idle_inputs();
  endtask

  task automatic test_reset();
    int n, leaked;
    idle_inputs();
    reset = 1'b1;
    rd_en = 2'b11;
    repeat (3) tick();
    n_checks++;
    if (init_busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b want 1", init_busy); end
    n_checks++;
    if (rd_valid !== 2'b00) begin n_errors++; $display("FAIL reset_valid: got %b want 00", rd_valid); end
    n_checks++;
    if (rd_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h want 0", rd_data); end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hBAD0BAD0; rd_en = 2'b11;
    release_and_count(n, leaked);
    n_checks++;
    if (n !== 32) begin n_errors++; $display("FAIL init_len: got %0d cycles want 32", n); end
    n_checks++;
    if (leaked !== 0) begin n_errors++; $display("FAIL init_rd_valid: got %0d valid cycles want 0", leaked); end
    clear_model();
  endtask

  task automatic test_init_zero();
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_en = 2'b11;
      rd_addr = {AW'(i + 1), AW'(i)};
      tick();
      if (rd_valid !== 2'b11 || rd_data !== '0) begin
        bad++;
        $display("FAIL init_zero: idx %0d got valid=%b data=%h want 11/0", i, rd_valid, rd_data);
      end
    end
    n_checks++;
    if (bad !== 0) n_errors++;
    idle_inputs();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    ref_mem[5] = 32'hDEADBEEF;
    idle_inputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    n_checks++;
    if (rd_valid !== 2'b01) begin n_errors++; $display("FAIL wr_rd_valid: got %b want 01", rd_valid); end
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL wr_rd_data: got %h want deadbeef", rd_data[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
    tick();
    idle_inputs();
    rd_en = 2'b11; rd_addr = {5'd31, 5'd31};
    tick();
    n_checks++;
    if (rd_valid !== 2'b11 || rd_data !== '0) begin
      n_errors++; $display("FAIL zero_reg: got valid=%b data=%h want 11/0", rd_valid, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    logic [WIDTH-1:0] exp;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    tick();
    ref_mem[7] = 32'h1;
    wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    exp = BYPASS ? 32'hA5A5A5A5 : 32'h1;
    tick();
    ref_mem[7] = 32'hA5A5A5A5;
    n_checks++;
    if (rd_valid !== 2'b10 || rd_data[63:32] !== exp) begin
      n_errors++; $display("FAIL same_cycle: got valid=%b data=%h want 10/%h", rd_valid, rd_data[63:32], exp);
    end
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (rd_data[63:32] !== 32'hA5A5A5A5) begin
      n_errors++; $display("FAIL after_write: got %h want a5a5a5a5", rd_data[63:32]);
    end
    idle_inputs();
  endtask

  task automatic test_multi_read_hold();
    logic [WIDTH-1:0] w9;
    w9 = $urandom;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; tick();
    wr_addr = 5'd4; wr_data = 32'h44; tick();
    ref_mem[3] = 32'h33; ref_mem[4] = 32'h44;
    wr_addr = 5'd9; wr_data = w9;
    rd_en = 2'b11; rd_addr = {5'd4, 5'd3};
    tick();
    ref_mem[9] = w9;
    n_checks++;
    if (rd_valid !== 2'b11 || rd_data !== {32'h44, 32'h33}) begin
      n_errors++; $display("FAIL dual_read: got valid=%b data=%h want 11/%h", rd_valid, rd_data, {32'h44, 32'h33});
    end
    idle_inputs();
    tick();
    n_checks++;
    if (rd_valid !== 2'b00 || rd_data !== {32'h44, 32'h33}) begin
      n_errors++; $display("FAIL hold: got valid=%b data=%h want 00/%h", rd_valid, rd_data, {32'h44, 32'h33});
    end
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    tick();
    n_checks++;
    if (rd_data[63:32] !== w9 || rd_data[31:0] !== 32'h33) begin
      n_errors++; $display("FAIL reg9: got %h want %h_%h", rd_data, w9, 32'h33);
    end
    idle_inputs();
  endtask

  task automatic test_reset_restart();
    int n, leaked;
    reset = 1'b1; tick();
    reset = 1'b0; repeat (10) tick();
    reset = 1'b1; tick();
    n_checks++;
    if (init_busy !== 1'b1 || rd_valid !== 2'b00 || rd_data !== '0) begin
      n_errors++; $display("FAIL midsweep_reset: got busy=%b valid=%b data=%h want 1/00/0", init_busy, rd_valid, rd_data);
    end
    release_and_count(n, leaked);
    n_checks++;
    if (n !== 32 || leaked !== 0) begin
      n_errors++; $display("FAIL restart_len: got %0d cycles (%0d valid) want 32 (0)", n, leaked);
    end
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFF; tick();
    idle_inputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd2}; tick();
    n_checks++;
    if (rd_data[31:0] !== 32'hFF) begin n_errors++; $display("FAIL reg2_ff: got %h want ff", rd_data[31:0]); end
    idle_inputs();
    reset = 1'b1; tick();
    release_and_count(n, leaked);
    n_checks++;
    if (n !== 32) begin n_errors++; $display("FAIL ready_reset_len: got %0d want 32", n); end
    clear_model();
    rd_en = 2'b11; rd_addr = {5'd5, 5'd2}; tick();
    n_checks++;
    if (rd_valid !== 2'b11 || rd_data !== '0) begin
      n_errors++; $display("FAIL recleared: got valid=%b data=%h want 11/0", rd_valid, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_d [NUM_RD];
    logic [NUM_RD-1:0] exp_v;
    int ra [NUM_RD];
    int wa, bad;
    bit we;
    logic [WIDTH-1:0] wd;
    logic [NUM_RD-1:0] re;
    bad = 0;
    for (int p = 0; p < NUM_RD; p++) exp_d[p] = '0;
    for (int it = 0; it < 400; it++) begin
      we = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 31);
      wd = $urandom;
      re = (it == 0) ? 2'b11 : NUM_RD'($urandom_range(0, 3));
      for (int p = 0; p < NUM_RD; p++) begin
        ra[p] = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 31);
        if (re[p]) exp_d[p] = model_read(ra[p], we, wa, wd);
      end
      exp_v = re;
      wr_en = we; wr_addr = AW'(wa); wr_data = wd;
      rd_en = re; rd_addr = {AW'(ra[1]), AW'(ra[0])};
      tick();
      if (we && wa != ZREG) ref_mem[wa] = wd;
      n_checks++;
      if (rd_valid !== exp_v) begin
        n_errors++; bad++;
        $display("FAIL rand_valid it%0d: got %b want %b", it, rd_valid, exp_v);
      end
      for (int p = 0; p < NUM_RD; p++) begin
        n_checks++;
        if (rd_data[p*WIDTH +: WIDTH] !== exp_d[p]) begin
          n_errors++; bad++;
          $display("FAIL rand_data it%0d port%0d: got %h want %h", it, p, rd_data[p*WIDTH +: WIDTH], exp_d[p]);
        end
      end
      if (bad > 20) break;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    clear_model();
    test_reset();
    test_init_zero();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_multi_read_hold();
    test_reset_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
